// File: rtl/scaler_pkg.sv
// Shared types for the scaler front end: pixel width default, coordinate
// type and the 2x2 window record.
package scaler_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int COORD_W   = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] p00;
    logic [PIX_W_DEF-1:0] p01;
    logic [PIX_W_DEF-1:0] p10;
    logic [PIX_W_DEF-1:0] p11;
  } win_t;

endpackage

// File: rtl/win2x2_gen_if.sv
// Video stream in, 2x2 window out. The source drives the i_* side (master);
// the window generator consumes it and drives the o_* side (slave).
interface win2x2_gen_if
  import scaler_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIX_W_DEF
);

  logic                   i_vsync;
  logic                   i_hsync;
  logic                   i_data_valid;
  logic [PIXEL_WIDTH-1:0] i_data;

  logic [PIXEL_WIDTH-1:0] o_p00;
  logic [PIXEL_WIDTH-1:0] o_p01;
  logic [PIXEL_WIDTH-1:0] o_p10;
  logic [PIXEL_WIDTH-1:0] o_p11;
  coord_t                 o_x;
  coord_t                 o_y;
  logic                   o_valid;
  logic                   o_eof;
  logic                   o_line_err;
  logic                   o_overflow;

  modport master (
    output i_vsync, i_hsync, i_data_valid, i_data,
    input  o_p00, o_p01, o_p10, o_p11, o_x, o_y,
           o_valid, o_eof, o_line_err, o_overflow
  );

  modport slave (
    input  i_vsync, i_hsync, i_data_valid, i_data,
    output o_p00, o_p01, o_p10, o_p11, o_x, o_y,
           o_valid, o_eof, o_line_err, o_overflow
  );

endinterface

// File: rtl/win2x2_gen_line_ram.sv
// Simple dual-port line buffer: read-first, one-cycle read latency.
// Contents are deliberately not reset.
module line_ram #(
  parameter int DEPTH  = 640,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write and registered read; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/win2x2_gen.sv
// 2x2 sliding-window generator: one line buffer supplies the upper row,
// a two-stage pipeline assembles the window two cycles after each pixel.
module win2x2_gen
  import scaler_pkg::*;
#(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int PIXEL_WIDTH = PIX_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  win2x2_gen_if.slave  bus
);

  localparam int     ADDR_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam coord_t LAST_COL = coord_t'(IMG_WIDTH - 1);
  localparam coord_t LAST_ROW = coord_t'(IMG_HEIGHT - 1);
  localparam coord_t FULL_ROW = coord_t'(IMG_HEIGHT);

  coord_t                 col_r, row_r;
  logic                   armed_r, hsync_d_r;
  logic                   line_err_r, overflow_r;
  logic                   hs_rise_s, frame_full_s, beat_s;
  logic                   accept_s, overflow_hit_s, short_line_s;
  logic [PIXEL_WIDTH-1:0] upper_s;

  logic                   s1_valid_r;
  logic [PIXEL_WIDTH-1:0] s1_pix_r;
  coord_t                 s1_x_r, s1_y_r;

  logic [PIXEL_WIDTH-1:0] p00_r, p01_r, p10_r, p11_r;
  coord_t                 x_r, y_r;
  logic                   valid_r, eof_r;

  // Beat qualification; nothing is accepted until a vsync has armed the block.
  always_comb begin
    hs_rise_s      = bus.i_hsync & ~hsync_d_r;
    frame_full_s   = (row_r == FULL_ROW);
    beat_s         = bus.i_data_valid & ~bus.i_vsync & ~bus.i_hsync & armed_r;
    accept_s       = beat_s & ~frame_full_s;
    overflow_hit_s = beat_s & frame_full_s;
    short_line_s   = hs_rise_s & (col_r != 16'd0) & ~bus.i_vsync;
  end

  // Position counters, hsync edge detect and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r      <= 16'd0;
      row_r      <= 16'd0;
      armed_r    <= 1'b0;
      hsync_d_r  <= 1'b0;
      line_err_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      hsync_d_r  <= bus.i_hsync;
      armed_r    <= armed_r | bus.i_vsync;
      line_err_r <= short_line_s;
      overflow_r <= bus.i_vsync ? 1'b0 : (overflow_r | overflow_hit_s);
      if (bus.i_vsync) begin
        col_r <= 16'd0;
        row_r <= 16'd0;
      end else if (short_line_s) begin
        col_r <= 16'd0;
        row_r <= row_r + 16'd1;
      end else if (accept_s) begin
        if (col_r == LAST_COL) begin
          col_r <= 16'd0;
          row_r <= row_r + 16'd1;
        end else begin
          col_r <= col_r + 16'd1;
        end
      end
    end
  end

  line_ram #(
    .DEPTH  (IMG_WIDTH),
    .WIDTH  (PIXEL_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_line_ram (
    .clk   (clk),
    .we    (accept_s),
    .waddr (col_r[ADDR_W-1:0]),
    .wdata (bus.i_data),
    .re    (accept_s),
    .raddr (col_r[ADDR_W-1:0]),
    .rdata (upper_s)
  );

  // Stage 1: align the pixel and its position with the RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_pix_r   <= '0;
      s1_x_r     <= 16'd0;
      s1_y_r     <= 16'd0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_pix_r <= bus.i_data;
        s1_x_r   <= col_r;
        s1_y_r   <= row_r;
      end
    end
  end

  // Stage 2: shift the window left one column; the window is complete only away from the top/left edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p00_r   <= '0;
      p01_r   <= '0;
      p10_r   <= '0;
      p11_r   <= '0;
      x_r     <= 16'd0;
      y_r     <= 16'd0;
      valid_r <= 1'b0;
      eof_r   <= 1'b0;
    end else begin
      valid_r <= s1_valid_r & (s1_x_r != 16'd0) & (s1_y_r != 16'd0);
      eof_r   <= s1_valid_r & (s1_x_r == LAST_COL) & (s1_y_r == LAST_ROW);
      if (s1_valid_r) begin
        p11_r <= s1_pix_r;
        p01_r <= upper_s;
        p10_r <= p11_r;
        p00_r <= p01_r;
        x_r   <= s1_x_r;
        y_r   <= s1_y_r;
      end
    end
  end

  assign bus.o_p00      = p00_r;
  assign bus.o_p01      = p01_r;
  assign bus.o_p10      = p10_r;
  assign bus.o_p11      = p11_r;
  assign bus.o_x        = x_r;
  assign bus.o_y        = y_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_eof      = eof_r;
  assign bus.o_line_err = line_err_r;
  assign bus.o_overflow = overflow_r;

endmodule

// File: tb/tb_win2x2_gen.sv
// Bench for win2x2_gen on a 4x3 image: a pixel-level frame model predicts
// every output each cycle, and literal windows pin the model.
module tb_win2x2_gen;
  import scaler_pkg::*;

  localparam int W = 4;
  localparam int H = 3;
  localparam int PW = 8;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   rst_next = 1'b1;
  always #5 clk = ~clk;

  win2x2_gen_if #(.PIXEL_WIDTH(PW)) bus ();

  win2x2_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vec = 0;
  int miss = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // model: frame position, last sample stored per column, previous pixel
  int          m_col, m_row;
  bit          m_armed, m_phs, m_ovf;
  logic [7:0]  mem [W];
  bit          mem_k [W];
  logic [7:0]  last_p, last_up;
  bit          last_k;

  bit   e_upd [MAXC];
  bit   e_valid [MAXC];
  bit   e_eof [MAXC];
  bit   e_lerr [MAXC];
  bit   e_ovf [MAXC];
  bit   e_k01 [MAXC];
  bit   e_k00 [MAXC];
  win_t e_win [MAXC];
  int   e_x [MAXC];
  int   e_y [MAXC];

  win_t cur;
  int   cur_x, cur_y;
  bit   cur_k01, cur_k00;
  int   n_valid, n_eof, n_lerr, t_first, t_in;
  bit   want_t;
  win_t first_w, last_w;
  int   first_x, first_y, last_x, last_y;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Predict the outputs caused by the inputs sampled at the coming edge.
  task automatic model_step();
    int c, d;
    logic [7:0] up;
    bit k;
    c = cyc + 1;
    e_lerr[c] = 1'b0;
    if (rst) begin
      for (int i = c; i <= c + 1; i++) begin
        e_upd[i] = 1'b0; e_valid[i] = 1'b0; e_eof[i] = 1'b0; e_lerr[i] = 1'b0;
      end
      m_col = 0; m_row = 0; m_armed = 1'b0; m_phs = 1'b0; m_ovf = 1'b0;
      last_p = 8'h00; last_up = 8'h00; last_k = 1'b1;
      e_ovf[c] = 1'b0;
      return;
    end
    if (bus.i_vsync) begin
      m_col = 0; m_row = 0; m_armed = 1'b1; m_ovf = 1'b0;
    end else if (bus.i_hsync && !m_phs && m_col != 0) begin
      m_col = 0; m_row++; e_lerr[c] = 1'b1;
    end else if (bus.i_data_valid && !bus.i_hsync && m_armed) begin
      if (m_row == H) begin
        m_ovf = 1'b1;
      end else begin
        d = c + 1;
        up = mem[m_col]; k = mem_k[m_col];
        mem[m_col] = bus.i_data; mem_k[m_col] = 1'b1;
        e_upd[d] = 1'b1;
        e_win[d].p00 = last_up; e_win[d].p01 = up;
        e_win[d].p10 = last_p;  e_win[d].p11 = bus.i_data;
        e_k00[d] = last_k; e_k01[d] = k;
        e_x[d] = m_col; e_y[d] = m_row;
        e_valid[d] = (m_col >= 1) && (m_row >= 1);
        e_eof[d] = (m_col == W - 1) && (m_row == H - 1);
        last_p = bus.i_data; last_up = up; last_k = k;
        if (m_col == W - 1) begin m_col = 0; m_row++; end
        else m_col++;
      end
    end
    m_phs = bus.i_hsync;
    e_ovf[c] = m_ovf;
  endtask

  task automatic check_cycle(input int c);
    if (rst) begin
      cur = '0; cur_x = 0; cur_y = 0; cur_k01 = 1'b1; cur_k00 = 1'b1;
    end else if (e_upd[c]) begin
      cur = e_win[c]; cur_x = e_x[c]; cur_y = e_y[c];
      cur_k01 = e_k01[c]; cur_k00 = e_k00[c];
    end
    chk("o_valid", bus.o_valid, e_valid[c]);
    chk("o_eof", bus.o_eof, e_eof[c]);
    chk("o_line_err", bus.o_line_err, e_lerr[c]);
    chk("o_overflow", bus.o_overflow, e_ovf[c]);
    chk("o_x", bus.o_x, cur_x);
    chk("o_y", bus.o_y, cur_y);
    chk("o_p11", bus.o_p11, cur.p11);
    chk("o_p10", bus.o_p10, cur.p10);
    if (cur_k01) chk("o_p01", bus.o_p01, cur.p01);
    if (cur_k00) chk("o_p00", bus.o_p00, cur.p00);
    if (bus.o_valid) begin
      n_valid++;
      last_w = {bus.o_p00, bus.o_p01, bus.o_p10, bus.o_p11};
      last_x = bus.o_x; last_y = bus.o_y;
      if (n_valid == 1) begin
        first_w = last_w; first_x = last_x; first_y = last_y; t_first = c;
      end
    end
    if (bus.o_eof) n_eof++;
    if (bus.o_line_err) n_lerr++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (chk_on) check_cycle(cyc);
    end
  end

  function automatic logic [7:0] pix(input int y, input int x, input bit inv);
    logic [7:0] v;
    v = 8'(16 * y + x);
    return inv ? ~v : v;
  endfunction

  task automatic tick(input bit vs, input bit hs, input bit dv, input logic [7:0] d);
    @(negedge clk);
    rst = rst_next;
    bus.i_vsync = vs; bus.i_hsync = hs; bus.i_data_valid = dv; bus.i_data = d;
    if (want_t && dv && d == 8'h11) begin t_in = cyc; want_t = 1'b0; end
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_line(input int y, input int n, input bit inv, input int nblank);
    for (int x = 0; x < n; x++) tick(1'b0, 1'b0, 1'b1, pix(y, x, inv));
    for (int b = 0; b < nblank; b++) tick(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic frame(input bit inv, input int last_blank);
    send_line(0, W, inv, 2);
    send_line(1, W, inv, 2);
    send_line(2, W, inv, last_blank);
  endtask

  task automatic clear_stats();
    n_valid = 0; n_eof = 0; n_lerr = 0;
  endtask

  initial begin
    bus.i_vsync = 1'b0; bus.i_hsync = 1'b0; bus.i_data_valid = 1'b0; bus.i_data = 8'h00;
    want_t = 1'b0; t_in = 0; t_first = 0;
    rst_next = 1'b1;
    chk_on = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_overflow", bus.o_overflow, 0);
    chk("rst_x", bus.o_x, 0);
    chk("rst_p11", bus.o_p11, 0);
    rst_next = 1'b0;
    idle(2);

    // full frame
    vsync(2);
    clear_stats();
    want_t = 1'b1;
    frame(1'b0, 2);
    idle(4);
    chk("frame_windows", n_valid, 6);
    chk("first_x", first_x, 1);
    chk("first_y", first_y, 1);
    chk("first_win", first_w, 32'h00011011);
    chk("first_latency", t_first - t_in, 2);
    chk("last_pos", last_x * 16 + last_y, 8'h32);
    chk("last_win", last_w, 32'h12132223);
    chk("eof_count", n_eof, 1);

    // line 1 cut short
    vsync(1);
    clear_stats();
    send_line(0, W, 1'b0, 2);
    send_line(1, 2, 1'b0, 2);
    send_line(2, W, 1'b0, 2);
    idle(4);
    chk("short_lerr_count", n_lerr, 1);
    chk("short_windows", n_valid, 4);
    chk("short_first_win", first_w, 32'h00011011);
    chk("short_last_pos", last_x * 16 + last_y, 8'h32);
    chk("short_last_win", last_w, 32'h02032223);

    // 13th pixel overflows
    vsync(1);
    clear_stats();
    frame(1'b0, 2);
    tick(1'b0, 1'b0, 1'b1, 8'h55);
    idle(3);
    chk("ovf_windows", n_valid, 6);
    chk("ovf_set", bus.o_overflow, 1);
    vsync(1);
    idle(1);
    chk("ovf_cleared", bus.o_overflow, 0);

    // reset mid-line, frame without vsync ignored
    vsync(1);
    send_line(0, W, 1'b0, 2);
    send_line(1, 2, 1'b0, 0);
    rst_next = 1'b1;
    idle(2);
    rst_next = 1'b0;
    clear_stats();
    frame(1'b0, 2);
    idle(3);
    chk("post_rst_no_windows", n_valid, 0);
    vsync(1);
    clear_stats();
    frame(1'b0, 2);
    idle(4);
    chk("post_rst_windows", n_valid, 6);
    chk("post_rst_last_win", last_w, 32'h12132223);

    // back-to-back frames, 1-cycle vsync, second frame inverted
    vsync(1);
    clear_stats();
    frame(1'b0, 0);
    vsync(1);
    frame(1'b1, 2);
    idle(4);
    chk("b2b_windows", n_valid, 12);
    chk("b2b_eof_count", n_eof, 2);
    chk("b2b_last_pos", last_x * 16 + last_y, 8'h32);
    chk("b2b_last_win", last_w, 32'hEDECDDDC);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/win2x2_gen.md
WIN2X2_GEN -- requirements
Module: win2x2_gen

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, giving active pixels per line.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, giving active lines per frame.
REQ-003 The block SHALL have parameter PIXEL_WIDTH, default 8, giving bits per grayscale sample.
REQ-004 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port i_vsync, input, 1, high during vertical blanking.
REQ-007 The block SHALL have port i_hsync, input, 1, high during horizontal blanking.
REQ-008 The block SHALL have port i_data_valid, input, 1, marking a valid active pixel.
REQ-009 The block SHALL have port i_data, input, PIXEL_WIDTH, the grayscale sample (R channel of the stream).
REQ-010 The block SHALL have ports o_p00, o_p01, o_p10 and o_p11, each output, PIXEL_WIDTH, holding the window (y-1,x-1), (y-1,x), (y,x-1) and (y,x) respectively.
REQ-011 The block SHALL have ports o_x and o_y, output, 16 each, giving the column and row of o_p11.
REQ-012 The block SHALL have port o_valid, output, 1, marking a complete 2x2 window.
REQ-013 The block SHALL have port o_eof, output, 1, pulsing with the window at (IMG_WIDTH-1, IMG_HEIGHT-1).
REQ-014 The block SHALL have port o_line_err, output, 1, a one-cycle pulse on a short line.
REQ-015 The block SHALL have port o_overflow, output, 1, sticky and cleared by i_vsync high.

Function
REQ-016 Column counter col SHALL increment on each i_data_valid beat and wrap at IMG_WIDTH-1 to 0, at which point row increments.
REQ-017 i_vsync high SHALL clear col and row to 0 in the next cycle, including mid-line.
REQ-018 A rising edge of i_hsync with col!=0 SHALL force col to 0, increment row and pulse o_line_err one cycle later.
REQ-019 Beats arriving when row==IMG_HEIGHT SHALL be discarded, with no RAM write and no o_valid, and SHALL set o_overflow.
REQ-020 The line RAM SHALL hold IMG_WIDTH samples and be read and written at address col on every accepted beat, read-first, with 1-cycle read latency.
REQ-021 Stage 1 SHALL register the pixel, col, row and valid; the RAM output at stage 1 SHALL be the upper-row sample.
REQ-022 On a stage-1 valid beat, stage 2 SHALL load o_p11<=pixel, o_p01<=upper, o_p10<=old o_p11 and o_p00<=old o_p01.
REQ-023 On non-valid cycles, o_p00, o_p01, o_p10, o_p11, o_x and o_y SHALL hold their values.
REQ-024 o_valid SHALL be asserted exactly 2 cycles after the accepted input beat, and only when x>=1 and y>=1.
REQ-025 The block SHALL produce exactly (IMG_WIDTH-1)*(IMG_HEIGHT-1) windows per well-formed frame.
REQ-026 A beat already in stage 1 when i_vsync rises SHALL still complete, and 2-cycle latency SHALL be kept.
REQ-027 Back-to-back frames with a single-cycle i_vsync pulse SHALL be supported.
REQ-028 The block SHALL apply no backpressure, and throughput SHALL be 1 pixel per clock.

Reset
REQ-029 rst high SHALL asynchronously clear all outputs, counters, pipeline valids and the hsync edge register to 0.
REQ-030 Line RAM contents SHALL NOT be reset, and no window using stale RAM SHALL be emitted, since y>=1 is required.
REQ-031 After rst deasserts mid-frame, the block SHALL emit no o_valid until the first i_vsync high has been seen.

Structure
REQ-032 Package scaler_pkg SHALL hold the default PIXEL_WIDTH, the 16-bit coordinate typedef coord_t and the window struct type.
REQ-033 Sub-module line_ram SHALL be a simple dual-port, read-first, 1-cycle-latency RAM, parameterized by depth and width, with no reset.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, pixel=16*y+x, 2 blank cycles per line)
REQ-034 Full frame -> exactly 6 o_valid; the first, at (1,1), 2 cycles after pixel 0x11 is input, carries p00/p01/p10/p11=0x00/0x01/0x10/0x11.
REQ-035 Last window -> (3,2) with 0x12/0x13/0x22/0x23 and o_eof=1 on the same cycle only.
REQ-036 Line 1 cut to 2 pixels, then hsync -> o_line_err single pulse; the next line is treated as y=2 and col restarts at 0.
REQ-037 A 13th pixel before vsync -> no o_valid and o_overflow=1 until i_vsync high.
REQ-038 rst pulsed during line 1, then a full frame -> no o_valid before the next vsync, then 6 correct windows.
REQ-039 Two frames with a 1-cycle vsync gap and the second frame inverted (~pixel) -> 12 windows, with the second frame matching inverted values.
